// File: rtl/divu_seq.sv
// divu_seq: sequential unsigned divider, restoring shift-subtract, one quotient bit per clock.
// Result word is {remainder, quotient}; a zero divisor yields {dividend, all-ones} and sets div_zero.
module divu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'b011011,
  parameter logic [5:0]  OUT   = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] shl;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;

  // Trial subtract; the remainder MSB shifted out of the window is kept as bit WIDTH so
  // divisors >= 2^(WIDTH-1) still produce exact results.
  assign shl   = {rem_q, quo_q} << 1;
  assign trial = {rem_q[WIDTH-1], shl[2*WIDTH-1:WIDTH]};
  assign diff  = trial - {1'b0, dvsr_q};

  // Next-state and datapath update for the IDLE/RUN/FIN sequence plus the OUT read port.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    dout_d  = dout_q;

    if (Signal == OUT) begin
      dout_d = res_q;
    end

    case (state_q)
      S_IDLE: begin
        if (Signal == DIVU) begin
          dvsr_d  = dataB;
          quo_d   = dataA;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = (dataB == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {shl[WIDTH-1:1], 1'b1};
        end else begin
          rem_d = shl[2*WIDTH-1:WIDTH];
          quo_d = shl[WIDTH-1:0];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dvsr_q == '0) begin
          res_d = {quo_q, {WIDTH{1'b1}}};
          dz_d  = 1'b1;
        end else begin
          res_d = {rem_q, quo_q};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign dataOut  = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: scoreboard bench for divu_seq; expected words are queued at start and checked on OUT.
module tb_divu_seq;

  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] OUT  = 6'b111111;
  localparam logic [5:0] NOP  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        div_zero;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_edge = 0;
  logic [64:0] exp_q[$];
  logic [63:0] last_res = '0;

  divu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .dataA    (dataA),
    .dataB    (dataB),
    .Signal   (Signal),
    .dataOut  (dataOut),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Bit 64 = expected div_zero, bits 63:0 = expected result word
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    return {1'b0, a % b, a / b};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA = a;
    dataB = b;
    Signal = DIVU;
    exp_q.push_back(ref_div(a, b));
    start_edge = cyc + 1;
    @(negedge clk);
    Signal = NOP;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("dz_clear_at_start", 64'(div_zero), 64'd0);
  endtask

  task automatic wait_done();
    logic [64:0] e;
    bit seen;
    int lat;
    seen = 1'b0;
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    lat = cyc - start_edge;
    chk("latency", 64'(lat), e[64] ? 64'd1 : 64'd33);
    chk("div_zero", 64'(div_zero), 64'(e[64]));
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic read_out();
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      Signal = OUT;
      @(negedge clk);
      Signal = NOP;
      chk("dataOut", dataOut, e[63:0]);
      last_res = e[63:0];
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_done();
    read_out();
  endtask

  // Main stimulus sequence
  initial begin
    logic [64:0] drop;
    int done_cnt;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    Signal = NOP;
    dataA = '0;
    dataB = '0;
    repeat (2) @(negedge clk);
    chk("rst_dataOut", dataOut, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;

    run_div(32'd100, 32'd7);
    run_div(32'hFFFF_FFFF, 32'd1);
    run_div(32'hFFFF_FFFF, 32'h8000_0000);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_div(32'd3, 32'd10);
    run_div(32'd5, 32'd0);
    run_div(32'd9, 32'd3);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_div(ra, rb);
    end

    // Start while busy is ignored
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    dataA = 32'd8;
    dataB = 32'd2;
    Signal = DIVU;
    @(negedge clk);
    Signal = NOP;
    dataA = '0;
    dataB = '0;
    wait_done();
    read_out();

    // OUT during a run returns the previous result
    start_op(32'd50, 32'd5);
    repeat (5) @(negedge clk);
    Signal = OUT;
    @(negedge clk);
    Signal = NOP;
    chk("out_during_run", dataOut, last_res);
    wait_done();
    read_out();

    // Reset mid-division aborts without a done pulse
    start_op(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    chk("abort_dataOut", dataOut, 64'd0);
    drop = exp_q.pop_front();
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_abort", 64'(done_cnt), 64'd0);

    run_div(32'd12, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
